// File: rtl/fetch_unit.sv
// fetch_unit: drives the PC register, issues in-order imem fetches and pairs
// each returned instruction with its PC in a small ring buffer feeding decode.
module fetch_unit #(
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_q,
  output logic [XLEN-1:0] pc_next,
  output logic            pc_enable,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [ILEN-1:0] if_instr
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int DW = 8;

  // Ring pointers carry one wrap bit so full and empty are distinct.
  // head: oldest slot, fill: oldest pending slot, tail: next free slot.
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   fill_q, fill_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [PW-1:0]   used;
  logic [PW-1:0]   outst;
  logic [DW-1:0]   drop_q, drop_d;
  logic            go_q;
  logic [XLEN-1:0] pcb_q [DEPTH];
  logic [ILEN-1:0] ins_q [DEPTH];

  logic redir;
  logic accept;
  logic rsp_in;
  logic rsp_drop;
  logic rsp_fill;
  logic pop;

  assign used  = tail_q - head_q;
  assign outst = tail_q - fill_q;

  // go_q holds off requests for the first cycle after reset release.
  assign redir  = redirect & go_q;
  assign accept = imem_req_valid & imem_req_ready;

  assign imem_req_valid = go_q & ~redirect & (used < PW'(DEPTH));
  assign imem_addr      = pc_q;

  assign pc_enable = redir | accept;
  assign pc_next   = !go_q ? '0
                   : redir ? redirect_pc
                   : pc_q + XLEN'(4);

  // Stale responses (from before a redirect) are consumed first.
  assign rsp_in   = imem_rsp_valid & go_q;
  assign rsp_drop = rsp_in & (drop_q != '0);
  assign rsp_fill = rsp_in & (drop_q == '0) & (outst != '0);

  assign if_valid = (fill_q != head_q);
  assign pop      = if_valid & if_ready & ~redir;

  assign if_pc    = if_valid ? pcb_q[head_q[AW-1:0]] : '0;
  assign if_instr = if_valid ? ins_q[head_q[AW-1:0]] : '0;

  // Drop count: on redirect every fetch still in flight becomes stale.
  always_comb begin
    drop_d = drop_q;
    if (redir) begin
      drop_d = drop_q + DW'(outst) - DW'(rsp_drop | rsp_fill);
    end else if (rsp_drop) begin
      drop_d = drop_q - DW'(1);
    end
  end

  // Pointer advance; redirect empties the ring.
  always_comb begin
    head_d = head_q;
    fill_d = fill_q;
    tail_d = tail_q;
    if (redir) begin
      head_d = '0;
      fill_d = '0;
      tail_d = '0;
    end else begin
      if (accept)   tail_d = tail_q + PW'(1);
      if (rsp_fill) fill_d = fill_q + PW'(1);
      if (pop)      head_d = head_q + PW'(1);
    end
  end

  // Control state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
      fill_q <= '0;
      tail_q <= '0;
      drop_q <= '0;
      go_q   <= 1'b0;
    end else begin
      head_q <= head_d;
      fill_q <= fill_d;
      tail_q <= tail_d;
      drop_q <= drop_d;
      go_q   <= 1'b1;
    end
  end

  // Slot payload: PC captured on accept, instruction on response.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pcb_q[i] <= '0;
        ins_q[i] <= '0;
      end
    end else begin
      if (accept) pcb_q[tail_q[AW-1:0]] <= pc_q;
      if (rsp_fill) ins_q[fill_q[AW-1:0]] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random traffic against a queue-based memory and
// instruction-stream model, plus directed scenarios with literal checks.
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        clock;
  logic        reset;
  logic [31:0] pc_q;
  logic [31:0] pc_next;
  logic        pc_enable;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  fetch_unit #(.XLEN(32), .ILEN(32), .DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .pc_q           (pc_q),
    .pc_next        (pc_next),
    .pc_enable      (pc_enable),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // PC register owned by the environment
  always @(posedge clock or negedge reset) begin
    if (!reset) pc_q <= '0;
    else if (pc_enable) pc_q <= pc_next;
  end

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } ment_t;

  ment_t       mem[$];
  logic [31:0] rdy[$];
  logic [31:0] acc_log[$];
  logic [31:0] pop_log[$];
  logic [31:0] exp_fetch;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int since = 0;
  int p_ready = 100;
  int p_ifr = 100;
  int p_redir = 0;
  int lat_lo = 1;
  int lat_hi = 1;
  bit          frc_redir = 0;
  logic [31:0] frc_pc = '0;
  bit          frc_ifr = 0;

  function automatic logic [31:0] hash(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  task automatic step();
    bit   started;
    bit   exp_rv;
    bit   acc;
    bit   rsp;
    bit   popx;
    int   fresh;
    ment_t e;
    started = (since > 0);
    imem_req_ready = ($urandom_range(99) < p_ready);
    if_ready = frc_ifr || ($urandom_range(99) < p_ifr);
    redirect = started && ($urandom_range(99) < p_redir);
    redirect_pc = $urandom & 32'hFFFF_FFFC;
    if (frc_redir) begin
      redirect = 1'b1;
      redirect_pc = frc_pc;
    end
    frc_redir = 0;
    frc_ifr = 0;
    rsp = (mem.size() > 0) && (mem[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data = rsp ? hash(mem[0].addr) : $urandom;
    #2;
    fresh = 0;
    foreach (mem[i]) if (!mem[i].stale) fresh++;
    exp_rv = started && !redirect && (fresh + rdy.size() < DEPTH);
    acc = exp_rv && imem_req_ready;
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    chk("imem_addr", imem_addr, pc_q);
    chk("pc_enable", 32'(pc_enable), 32'(redirect || acc));
    if (redirect) begin
      chk("pc_next_redir", pc_next, redirect_pc);
    end else if (acc) begin
      chk("pc_next_inc", pc_next, pc_q + 32'd4);
      chk("fetch_seq", pc_q, exp_fetch);
      acc_log.push_back(pc_next);
    end
    chk("if_valid", 32'(if_valid), 32'(rdy.size() > 0));
    if (rdy.size() > 0) begin
      chk("if_pc", if_pc, rdy[0]);
      chk("if_instr", if_instr, hash(rdy[0]));
    end
    popx = (rdy.size() > 0) && if_ready && !redirect;
    if (popx) pop_log.push_back(if_pc);
    // model update for the coming edge
    if (rsp) begin
      e = mem.pop_front();
      if (!e.stale && !redirect) rdy.push_back(e.addr);
    end
    if (redirect) begin
      foreach (mem[i]) mem[i].stale = 1'b1;
      rdy.delete();
      exp_fetch = redirect_pc;
    end else begin
      if (popx) void'(rdy.pop_front());
      if (acc) begin
        e.addr = pc_q;
        e.due = cyc + $urandom_range(lat_hi, lat_lo);
        e.stale = 1'b0;
        mem.push_back(e);
        exp_fetch = exp_fetch + 32'd4;
      end
    end
    @(posedge clock);
    #1;
    cyc++;
    since++;
  endtask

  task automatic model_clear();
    mem.delete();
    rdy.delete();
    acc_log.delete();
    pop_log.delete();
    exp_fetch = '0;
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    redirect = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    if_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    since = 0;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_zero_outs(string tag);
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    chk({tag, "_pc_enable"}, 32'(pc_enable), 32'd0);
    chk({tag, "_pc_next"}, pc_next, 32'd0);
    chk({tag, "_if_valid"}, 32'(if_valid), 32'd0);
    chk({tag, "_if_pc"}, if_pc, 32'd0);
    chk({tag, "_if_instr"}, if_instr, 32'd0);
  endtask

  initial begin
    bit hit;
    reset = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    if_ready = 1'b0;
    #1;
    chk_zero_outs("reset");

    // 1: streaming from PC 0
    reset_dut();
    p_ready = 100; p_ifr = 100; p_redir = 0; lat_lo = 1; lat_hi = 1;
    run(14);
    if (acc_log.size() >= 3 && pop_log.size() >= 3) begin
      chk("t1_pcn0", acc_log[0], 32'd4);
      chk("t1_pcn1", acc_log[1], 32'd8);
      chk("t1_pcn2", acc_log[2], 32'd12);
      chk("t1_ifpc0", pop_log[0], 32'd0);
      chk("t1_ifpc1", pop_log[1], 32'd4);
      chk("t1_ifpc2", pop_log[2], 32'd8);
    end else begin
      chk("t1_count", 32'(pop_log.size()), 32'd3);
    end

    // 2: decode stalled -> only DEPTH fetches
    reset_dut();
    p_ifr = 0;
    run(10);
    chk("t2_accepts", 32'(acc_log.size()), 32'(DEPTH));
    p_ifr = 100;
    run(8);

    // 3: memory not ready
    p_ready = 0;
    acc_log.delete();
    run(5);
    chk("t3_accepts", 32'(acc_log.size()), 32'd0);
    p_ready = 100;
    run(5);

    // 4: redirect with two fetches outstanding
    reset_dut();
    lat_lo = 3; lat_hi = 3; p_ifr = 0;
    run(3);
    frc_redir = 1; frc_pc = 32'h100;
    step();
    pop_log.delete();
    p_ifr = 100;
    run(15);
    if (pop_log.size() > 0) chk("t4_first_pc", pop_log[0], 32'h100);
    else chk("t4_pops", 32'd0, 32'd1);

    // 5: redirect coinciding with a response and a pop
    reset_dut();
    lat_lo = 1; lat_hi = 1; p_ifr = 0;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (rdy.size() > 0 && mem.size() > 0 && mem[0].due <= cyc) begin
        frc_redir = 1; frc_pc = 32'h200; frc_ifr = 1;
        step();
        chk("t5_squash", 32'(if_valid), 32'd0);
        hit = 1;
      end else begin
        step();
      end
    end
    if (!hit) chk("t5_reach", 32'd0, 32'd1);
    p_ifr = 100;
    run(10);

    // 6: PC wrap, then asynchronous reset mid-stream
    reset_dut();
    p_ready = 100; p_ifr = 100;
    step();
    frc_redir = 1; frc_pc = 32'hFFFF_FFFC;
    step();
    acc_log.delete();
    step();
    if (acc_log.size() > 0) chk("t6_wrap", acc_log[0], 32'd0);
    else chk("t6_accept", 32'd0, 32'd1);
    run(6);
    #2;
    reset = 1'b0;
    #1;
    chk_zero_outs("async");
    reset_dut();

    // random traffic
    for (int s = 0; s < 8; s++) begin
      p_ready = $urandom_range(100, 30);
      p_ifr = $urandom_range(100, 20);
      p_redir = $urandom_range(15, 2);
      lat_lo = 1;
      lat_hi = $urandom_range(4, 1);
      run(300);
      if (s == 4) reset_dut();
    end
    p_redir = 0; p_ready = 100; p_ifr = 100;
    run(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
